// File: rtl/parity_link_pkg.sv
// Shared definitions for the 8-bit parity link (transmit generator and receive checker).
package parity_link_pkg;

  localparam int LINK_DATA_W = 8;
  localparam int FRAME_LEN   = LINK_DATA_W + 1;
  localparam int PARITY_ODD  = 1;

  typedef struct packed {
    logic [LINK_DATA_W-1:0] data;
    logic                   perr;
  } frame_t;

  // acc is the XOR of the data bits; odd selects the expected total-frame parity.
  function automatic logic parity_err(input logic acc, input logic pbit, input logic odd);
    return (acc ^ pbit) != odd;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/parity_frame_checker.sv
// Receive side of the parity link: deserializes DATA_W+1 bit frames, checks parity,
// and presents each byte with its error flag through a single-entry valid/ready slot.
module parity_frame_checker
  import parity_link_pkg::*;
#(
  parameter int DATA_W = LINK_DATA_W,
  parameter int CNT_W  = 16,
  parameter int ODD    = PARITY_ODD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] m_data,
  output logic              m_perr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              overrun,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  perr_count,
  output logic [CNT_W-1:0]  ovr_count
);

  localparam int              CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]   PBIT_IDX = CW'(DATA_W);

  logic [CW-1:0]     r_bitcnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic [DATA_W-1:0] r_data;
  logic              r_perr;
  logic              r_valid;
  logic              r_overrun;

  logic w_complete;
  logic w_perr;
  logic w_load;

  // sof takes priority over completion, so a frame never completes on a sof cycle.
  always_comb begin
    w_complete = bit_valid & ~sof & (r_bitcnt == PBIT_IDX);
    w_perr     = parity_err(r_parity, bit_in, ODD != 0);
    w_load     = ~r_valid | m_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_data    <= '0;
      r_perr    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && m_ready) begin
        r_valid <= 1'b0;
      end
      if (sof) begin
        r_shift <= '0;
        if (bit_valid) begin
          r_shift[0] <= bit_in;
          r_parity   <= bit_in;
          r_bitcnt   <= CW'(1);
        end else begin
          r_parity <= 1'b0;
          r_bitcnt <= '0;
        end
      end else if (bit_valid) begin
        if (w_complete) begin
          r_bitcnt <= '0;
          r_parity <= 1'b0;
          if (w_load) begin
            r_data  <= r_shift;
            r_perr  <= w_perr;
            r_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end else begin
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (r_bitcnt == CW'(i)) begin
              r_shift[i] <= bit_in;
            end
          end
          r_parity <= r_parity ^ bit_in;
          r_bitcnt <= r_bitcnt + 1'b1;
        end
      end
    end
  end

  assign m_data  = r_data;
  assign m_perr  = r_perr;
  assign m_valid = r_valid;
  assign overrun = r_overrun;

  sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (w_complete),
    .count (frame_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_perr_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (w_complete & w_perr),
    .count (perr_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ovr_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (w_complete & ~w_load),
    .count (ovr_count)
  );

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized and directed bench for parity_frame_checker against a frame-level reference model.
module tb_parity_frame_checker;
  import parity_link_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, bit_in, bit_valid, sof, m_ready;
  logic [7:0] m_data, s_data;
  logic       m_perr, m_valid, overrun, s_perr, s_valid, s_overrun;
  logic [15:0] frame_count, perr_count, ovr_count;
  logic [1:0]  s_frame_count, s_perr_count, s_ovr_count;

  parity_frame_checker #(.DATA_W(8), .CNT_W(16), .ODD(1)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .m_data(m_data), .m_perr(m_perr), .m_valid(m_valid), .m_ready(m_ready),
    .overrun(overrun), .frame_count(frame_count), .perr_count(perr_count),
    .ovr_count(ovr_count)
  );

  parity_frame_checker #(.DATA_W(8), .CNT_W(2), .ODD(1)) dut_sat (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .m_data(s_data), .m_perr(s_perr), .m_valid(s_valid), .m_ready(m_ready),
    .overrun(s_overrun), .frame_count(s_frame_count), .perr_count(s_perr_count),
    .ovr_count(s_ovr_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bits collected since the last sof/reset/completion, plus the held frame.
  logic   m_bits[$];
  frame_t m_slot;
  logic   m_vld, m_ovr;
  int     m_fc, m_pc, m_oc, ms_fc, ms_pc, ms_oc;

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_slot = '0;
    m_vld  = 1'b0;
    m_ovr  = 1'b0;
    m_fc = 0; m_pc = 0; m_oc = 0; ms_fc = 0; ms_pc = 0; ms_oc = 0;
  endtask

  task automatic model_step(input logic r, input logic bv, input logic b,
                            input logic s, input logic rdy);
    logic [7:0] d;
    logic       pe;
    logic       was_vld;
    if (r) begin
      model_reset();
      return;
    end
    was_vld = m_vld;
    m_ovr = 1'b0;
    if (m_vld && rdy) m_vld = 1'b0;
    if (s) begin
      m_bits.delete();
      if (bv) m_bits.push_back(b);
    end else if (bv) begin
      if (m_bits.size() == 8) begin
        d = '0;
        for (int i = 0; i < 8; i++) d[i] = m_bits[i];
        pe = ((($countones(d) + int'(b)) % 2) == 1) ? 1'b0 : 1'b1;
        m_bits.delete();
        m_fc  = sat_inc(m_fc, 65535);
        ms_fc = sat_inc(ms_fc, 3);
        if (pe) begin
          m_pc  = sat_inc(m_pc, 65535);
          ms_pc = sat_inc(ms_pc, 3);
        end
        if (!was_vld || rdy) begin
          m_slot.data = d;
          m_slot.perr = pe;
          m_vld = 1'b1;
        end else begin
          m_ovr = 1'b1;
          m_oc  = sat_inc(m_oc, 65535);
          ms_oc = sat_inc(ms_oc, 3);
        end
      end else begin
        m_bits.push_back(b);
      end
    end
  endtask

  task automatic cycle(input logic r, input logic bv, input logic b,
                       input logic s, input logic rdy);
    rst = r; bit_valid = bv; bit_in = b; sof = s; m_ready = rdy;
    @(posedge clk);
    #1;
    model_step(r, bv, b, s, rdy);
    check("m_valid", 32'(m_valid), 32'(m_vld));
    check("m_data", 32'(m_data), 32'(m_slot.data));
    check("m_perr", 32'(m_perr), 32'(m_slot.perr));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("perr_count", 32'(perr_count), 32'(m_pc));
    check("ovr_count", 32'(ovr_count), 32'(m_oc));
    check("sat_frame_count", 32'(s_frame_count), 32'(ms_fc));
    check("sat_perr_count", 32'(s_perr_count), 32'(ms_pc));
    check("sat_ovr_count", 32'(s_ovr_count), 32'(ms_oc));
  endtask

  // One frame: 8 data bits LSB first then the parity bit; rdy_last applies on the parity cycle.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic with_sof,
                            input logic rdy, input logic rdy_last, input int gap);
    logic [8:0] f;
    f = {pbit, d};
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, f[i], with_sof && (i == 0), (i == 8) ? rdy_last : rdy);
      for (int g = 0; g < gap && i < 8; g++) cycle(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("first_frame_valid", 32'(m_valid), 32'd1);
    check("first_frame_data", 32'(m_data), 32'h00);
    idle(1, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("a5_perr", 32'(m_perr), 32'd1);
    idle(1, 1'b1);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    idle(2, 1'b1);

    // Flow control: second frame dropped while the first is held.
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("drop_overrun", 32'(overrun), 32'd1);
    check("held_data", 32'(m_data), 32'h5A);
    idle(1, 1'b1);

    // Accept coinciding with the next parity bit: no bubble, no overrun.
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    check("b2b_data", 32'(m_data), 32'h22);
    idle(1, 1'b1);

    // Resync via sof after a partial frame, then reset mid-frame.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("sof_data", 32'(m_data), 32'h3C);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_valid", 32'(m_valid), 32'd0);
    send_frame(8'h96, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    check("post_rst_data", 32'(m_data), 32'h96);

    // sof with bit_valid=0 clears the partial frame.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 0);

    // Saturation of the narrow-counter instance.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    check("sat_perr_hold", 32'(s_perr_count), 32'd3);
    check("sat_frame_hold", 32'(s_frame_count), 32'd3);

    // Random traffic, mostly aligned frames with occasional sof, resets and stalls.
    for (int n = 0; n < 3000; n++) begin
      logic r, bv, b, s, rdy;
      r   = ($urandom_range(0, 499) == 0);
      bv  = ($urandom_range(0, 9) < 6);
      b   = 1'($urandom);
      s   = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 9) < 5);
      cycle(r, bv, b, s, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
